pipe_datapath: RTL and testbench
================================

# pipe_datapath

Parametrised two-stage register-file/ALU datapath, successor to the single-cycle datapath: generic data width and register count, operand bypassing so back-to-back dependent instructions never stall, and a status-flag register. Sits between the decoder/controller (which supplies decoded fields every cycle) and the rest of the core. Results and flags are observed through a writeback port and a debug read port.

## Interface
- DATA_W, 8, data/register width (≥4)
- NUM_REGS, 16, register count (power of two, ≥2)
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decoded instruction present this cycle
- iss_dst  in  ADDR_W  destination register
- iss_src_a  in  ADDR_W  source A register
- iss_src_b  in  ADDR_W  source B register
- iss_imm  in  DATA_W  immediate
- iss_imm_sel  in  1  1: result = iss_imm (load-immediate, ALU bypassed); 0: ALU op
- iss_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 PASS_B
- iss_wr_en  in  1  write result to iss_dst; 0 = compare-only (flags still update)
- wb_valid  out  1  writeback stage holds a valid instruction
- wb_dst  out  ADDR_W  writeback destination
- wb_data  out  DATA_W  writeback result
- flags  out  4  {N, Z, C, V}, registered
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational read of register file at dbg_addr

## Operation
- Stage RD (issue cycle): read src A/B with bypass; capture operands, op, imm, dst, wr_en, imm_sel into EX register on edge when iss_valid=1; EX valid cleared when iss_valid=0.
- Stage EX/WB: ALU computes from EX register; on next edge, if EX valid and wr_en, register[dst] <= result; flags update if EX valid and imm_sel=0.
- Bypass: if EX valid, EX wr_en=1 and EX dst equals a source being read, that source takes the EX result instead of the file. Applies to A and B independently. dbg_data does NOT bypass.
- Arithmetic (modulo 2^DATA_W):
  - ADD: {C,res} = a + b; V = signed overflow.
  - SUB: res = a − b; C = 1 when a < b unsigned (borrow); V = signed overflow.
  - AND/OR/XOR/PASS_B: C = 0, V = 0.
  - SHL/SHR: shift a by b[$clog2(DATA_W)-1:0]; C = 0, V = 0; shift amount 0 yields a.
  - N = res[DATA_W-1]; Z = (res == 0).
- Load-immediate: result = iss_imm; flags unchanged.
- Writing and reading the same register in the same cycle: reader gets new value via bypass.
- No register is hardwired; register 0 is ordinary storage.

## Timing
- Reset (async assert, sync-free release): all registers 0, EX valid 0, flags 0000, wb_valid 0, wb_dst 0, wb_data 0.
- Latency: instruction sampled at edge k; wb_valid/wb_dst/wb_data valid during cycle after edge k; register file and flags updated at edge k+1; dbg_data shows new value after edge k+1.
- Throughput: one instruction per cycle, no stall, no backpressure.
- iss_valid=0 cycle: bubble; wb_valid=0 next cycle; wb_dst/wb_data hold last values.
- Reset asserted mid-operation: in-flight EX instruction discarded, no write, no flag update; first instruction after release behaves as from reset.

## Test plan
- Load r1=20 (edge 0), r3=10 (edge 1), ADD r5=r1+r3 (edge 2, r3 forwarded) -> wb_data=30 after edge 2; dbg r5=30 after edge 3; flags N=0 Z=0 C=0 V=0.
- SUB r6=r3−r1 with r3=10, r1=20 -> r6=0xF6, N=1 Z=0 C=1 V=0; SUB r1−r1 -> 0, Z=1 C=0.
- ADD 200+100 -> 44 (0x2C), C=1 V=0; ADD 100+100 -> 200 (0xC8), N=1 V=1 C=0.
- Dependency chain r2=1; r2=r2+r2 ×4 back-to-back -> r2=16, wb_data sequence 2,4,8,16.
- Compare-only: iss_wr_en=0 SUB r1−r1 with r1=20 -> Z=1, r1 still 20, no bypass to next instruction reading r1 (reads 20).
- Assert rst_n low one cycle after issuing ADD r7=r1+r3 -> r7=0, all registers 0, flags 0000, wb_valid=0; SHL r4=r1<<3 with r1=20 after reload -> 160 (0xA0).

Source files
------------

// File: rtl/pipe_datapath.sv
// Two-stage register-file/ALU datapath: RD stage captures bypassed operands,
// EX/WB stage computes the result, writes the register file and the status flags.
module pipe_datapath #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] iss_src_a,
  input  logic [ADDR_W-1:0] iss_src_b,
  input  logic [DATA_W-1:0] iss_imm,
  input  logic              iss_imm_sel,
  input  logic [2:0]        iss_op,
  input  logic              iss_wr_en,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_SHL    = 3'd5,
    OP_SHR    = 3'd6,
    OP_PASS_B = 3'd7
  } alu_op_t;

  logic [DATA_W-1:0] rf [NUM_REGS];

  logic              ex_valid;
  logic              ex_wr_en;
  logic              ex_imm_sel;
  logic [ADDR_W-1:0] ex_dst;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_imm;
  alu_op_t           ex_op;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ex_result;
  logic              c_out;
  logic              v_out;
  logic [3:0]        alu_flags;
  logic              fwd_en;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  always_comb begin
    sum     = {1'b0, ex_a} + {1'b0, ex_b};
    diff    = {1'b0, ex_a} - {1'b0, ex_b};
    alu_res = '0;
    c_out   = 1'b0;
    v_out   = 1'b0;
    case (ex_op)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        c_out   = sum[DATA_W];
        v_out   = (ex_a[MSB] == ex_b[MSB]) && (alu_res[MSB] != ex_a[MSB]);
      end
      OP_SUB: begin
        // the extra top bit of the widened difference is the unsigned borrow
        alu_res = diff[DATA_W-1:0];
        c_out   = diff[DATA_W];
        v_out   = (ex_a[MSB] != ex_b[MSB]) && (alu_res[MSB] != ex_a[MSB]);
      end
      OP_AND:    alu_res = ex_a & ex_b;
      OP_OR:     alu_res = ex_a | ex_b;
      OP_XOR:    alu_res = ex_a ^ ex_b;
      OP_SHL:    alu_res = ex_a << ex_b[SH_W-1:0];
      OP_SHR:    alu_res = ex_a >> ex_b[SH_W-1:0];
      OP_PASS_B: alu_res = ex_b;
      default:   alu_res = '0;
    endcase
    ex_result = ex_imm_sel ? ex_imm : alu_res;
    alu_flags = {alu_res[MSB], (alu_res == '0), c_out, v_out};
  end

  // Bypass from EX makes back-to-back dependent instructions see the new value.
  always_comb begin
    fwd_en = ex_valid && ex_wr_en;
    opnd_a = (fwd_en && (ex_dst == iss_src_a)) ? ex_result : rf[iss_src_a];
    opnd_b = (fwd_en && (ex_dst == iss_src_b)) ? ex_result : rf[iss_src_b];
  end

  // On a bubble only ex_valid drops; the held fields keep wb_dst/wb_data stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_wr_en   <= 1'b0;
      ex_imm_sel <= 1'b0;
      ex_dst     <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_op      <= OP_ADD;
    end else if (iss_valid) begin
      ex_valid   <= 1'b1;
      ex_wr_en   <= iss_wr_en;
      ex_imm_sel <= iss_imm_sel;
      ex_dst     <= iss_dst;
      ex_a       <= opnd_a;
      ex_b       <= opnd_b;
      ex_imm     <= iss_imm;
      ex_op      <= alu_op_t'(iss_op);
    end else begin
      ex_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      flags <= '0;
    end else begin
      if (ex_valid && ex_wr_en) rf[ex_dst] <= ex_result;
      if (ex_valid && !ex_imm_sel) flags <= alu_flags;
    end
  end

  assign wb_valid = ex_valid;
  assign wb_dst   = ex_dst;
  assign wb_data  = ex_result;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: directed vector table, reset corner case and
// randomized instruction stream against a sequential-execution reference model.
module tb_pipe_datapath;

  localparam int DW = 8;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_dst = '0;
  logic [AW-1:0] iss_src_a = '0;
  logic [AW-1:0] iss_src_b = '0;
  logic [DW-1:0] iss_imm = '0;
  logic          iss_imm_sel = 1'b0;
  logic [2:0]    iss_op = '0;
  logic          iss_wr_en = 1'b0;
  logic          wb_valid;
  logic [AW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic [3:0]    flags;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  pipe_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_dst(iss_dst),
    .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_imm(iss_imm),
    .iss_imm_sel(iss_imm_sel), .iss_op(iss_op), .iss_wr_en(iss_wr_en),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // architectural state (all issued instructions applied) and committed state
  int       a_regs [NR];
  int       c_regs [NR];
  logic [3:0] c_flags;
  logic     p_valid, p_wr, p_fupd;
  int       p_dst, p_res;
  logic [3:0] p_flags;
  int       last_dst, last_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int res, output logic [3:0] f);
    int sa, sb, ss;
    logic c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 1'b0; v = 1'b0; res = 0;
    case (op)
      0: begin res = (a + b) % 256; c = (a + b) >= 256; ss = sa + sb; v = (ss > 127) || (ss < -128); end
      1: begin res = (a - b + 256) % 256; c = a < b; ss = sa - sb; v = (ss > 127) || (ss < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a << (b % 8)) % 256;
      6: res = a >> (b % 8);
      default: res = b;
    endcase
    f = {res >= 128, res == 0, c, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin a_regs[i] = 0; c_regs[i] = 0; end
    c_flags = 4'b0000; p_valid = 1'b0; p_wr = 1'b0; p_fupd = 1'b0;
    p_dst = 0; p_res = 0; p_flags = 4'b0000; last_dst = 0; last_data = 0;
  endtask

  task automatic step(input logic v, input int dst, input int sa, input int sb,
                      input int imm, input logic isel, input int op,
                      input logic wr, input int dbg);
    int res;
    logic [3:0] f;
    @(negedge clk);
    iss_valid = v; iss_dst = AW'(dst); iss_src_a = AW'(sa); iss_src_b = AW'(sb);
    iss_imm = DW'(imm); iss_imm_sel = isel; iss_op = 3'(op); iss_wr_en = wr;
    dbg_addr = AW'(dbg);
    f = 4'b0000;
    if (isel) res = imm;
    else ref_alu(op, a_regs[sa], a_regs[sb], res, f);
    @(posedge clk);
    #1;
    if (p_valid && p_wr) c_regs[p_dst] = p_res;
    if (p_valid && p_fupd) c_flags = p_flags;
    p_valid = v; p_dst = dst; p_res = res; p_wr = wr; p_fupd = !isel; p_flags = f;
    if (v && wr) a_regs[dst] = res;
    if (v) begin last_dst = dst; last_data = res; end
    chk("wb_valid", int'(wb_valid), int'(v));
    chk("wb_dst", int'(wb_dst), last_dst);
    chk("wb_data", int'(wb_data), last_data);
    chk("flags", int'(flags), int'(c_flags));
    chk("dbg_data", int'(dbg_data), c_regs[dbg]);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk(name, int'(dbg_data), 0);
    end
  endtask

  typedef struct {
    logic v; int dst; int sa; int sb; int imm; logic isel; int op; logic wr;
    int exp_data; logic [3:0] exp_flags;
  } vec_t;

  function automatic vec_t mk(input logic v, input int dst, input int sa, input int sb,
                              input int imm, input logic isel, input int op, input logic wr,
                              input int exp_data, input logic [3:0] exp_flags);
    vec_t t;
    t.v = v; t.dst = dst; t.sa = sa; t.sb = sb; t.imm = imm; t.isel = isel;
    t.op = op; t.wr = wr; t.exp_data = exp_data; t.exp_flags = exp_flags;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [17];
    // exp_flags = flags visible once this instruction has committed
    tab[0]  = mk(1, 1, 0, 0, 20,  1, 0, 1, 20,   4'b0000);
    tab[1]  = mk(1, 3, 0, 0, 10,  1, 0, 1, 10,   4'b0000);
    tab[2]  = mk(1, 5, 1, 3, 0,   0, 0, 1, 30,   4'b0000);
    tab[3]  = mk(1, 6, 3, 1, 0,   0, 1, 1, 246,  4'b1010);
    tab[4]  = mk(1, 0, 1, 1, 0,   0, 1, 1, 0,    4'b0100);
    tab[5]  = mk(1, 8, 0, 0, 200, 1, 0, 1, 200,  4'b0100);
    tab[6]  = mk(1, 9, 0, 0, 100, 1, 0, 1, 100,  4'b0100);
    tab[7]  = mk(1, 10, 8, 9, 0,  0, 0, 1, 44,   4'b0010);
    tab[8]  = mk(1, 11, 9, 9, 0,  0, 0, 1, 200,  4'b1001);
    tab[9]  = mk(1, 2, 0, 0, 1,   1, 0, 1, 1,    4'b1001);
    tab[10] = mk(1, 2, 2, 2, 0,   0, 0, 1, 2,    4'b0000);
    tab[11] = mk(1, 2, 2, 2, 0,   0, 0, 1, 4,    4'b0000);
    tab[12] = mk(1, 2, 2, 2, 0,   0, 0, 1, 8,    4'b0000);
    tab[13] = mk(1, 2, 2, 2, 0,   0, 0, 1, 16,   4'b0000);
    tab[14] = mk(1, 1, 1, 1, 0,   0, 1, 0, 0,    4'b0100);
    tab[15] = mk(1, 12, 0, 1, 0,  0, 7, 1, 20,   4'b0000);
    tab[16] = mk(0, 13, 0, 0, 0,  0, 0, 1, 20,   4'b0000);

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_wb_dst", int'(wb_dst), 0);
    chk("rst_wb_data", int'(wb_data), 0);
    chk("rst_flags", int'(flags), 0);
    check_all_zero("rst_regs");

    for (int i = 0; i < 17; i++) begin
      step(tab[i].v, tab[i].dst, tab[i].sa, tab[i].sb, tab[i].imm, tab[i].isel,
           tab[i].op, tab[i].wr, 5);
      chk("tab_wb_data", int'(wb_data), tab[i].exp_data);
      chk("tab_flags", int'(flags), (i == 0) ? 0 : int'(tab[i-1].exp_flags));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("tab_r1_after_cmp", int'(dbg_data), 20);
    dbg_addr = AW'(2);  #1; chk("tab_r2_chain", int'(dbg_data), 16);
    dbg_addr = AW'(5);  #1; chk("tab_r5_add", int'(dbg_data), 30);
    dbg_addr = AW'(6);  #1; chk("tab_r6_sub", int'(dbg_data), 246);
    dbg_addr = AW'(12); #1; chk("tab_r12_nobypass", int'(dbg_data), 20);

    // reset while ADD r7=r1+r3 is in EX: it must be discarded
    step(1, 7, 1, 3, 0, 0, 0, 1, 0);
    @(negedge clk);
    iss_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_wb_valid", int'(wb_valid), 0);
    chk("midrst_wb_data", int'(wb_data), 0);
    chk("midrst_flags", int'(flags), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("midrst_regs");

    step(1, 1, 0, 0, 20, 1, 0, 1, 7);
    step(1, 2, 0, 0, 3,  1, 0, 1, 7);
    step(1, 4, 1, 2, 0,  0, 5, 1, 7);
    chk("shl_wb_data", int'(wb_data), 160);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4);
    chk("shl_r4", int'(dbg_data), 160);
    chk("shl_flags", int'(flags), 4'b1000);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(99) < 85, $urandom_range(NR-1), $urandom_range(NR-1),
           $urandom_range(NR-1), $urandom_range(255), $urandom_range(99) < 25,
           $urandom_range(7), $urandom_range(99) < 80, $urandom_range(NR-1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
